// File: rtl/synth_pkg.sv
// Shared types and helpers for the synth voice path.
package synth_pkg;

  parameter int unsigned SAMPLE_W  = 16;
  parameter int unsigned MAX_ORDER = 6;
  parameter int unsigned DEPTH     = 2 ** MAX_ORDER;
  parameter int unsigned PTR_W     = MAX_ORDER;
  parameter int unsigned ORD_W     = $clog2(MAX_ORDER + 1);
  parameter int unsigned SUM_W     = SAMPLE_W + MAX_ORDER;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {RUN, FLUSH} hpf_state_t;

  // Clamp a one-bit-wider signed value into sample_t range.
  function automatic sample_t sat_sample(input logic signed [SAMPLE_W:0] v);
    if (v[SAMPLE_W] != v[SAMPLE_W-1]) begin
      return v[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
    return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/moving_average_hpf_if.sv
// Sample stream bundle for the moving-average high-pass filter.
interface moving_average_hpf_if;
  import synth_pkg::*;

  logic [3:0] order;
  logic       in_valid;
  logic       in_ready;
  sample_t    signal_in;
  logic       out_valid;
  sample_t    signal_out;
  logic       settled;

  modport master (
    output order, in_valid, signal_in,
    input  in_ready, out_valid, signal_out, settled
  );

  modport slave (
    input  order, in_valid, signal_in,
    output in_ready, out_valid, signal_out, settled
  );

endinterface

// File: rtl/sample_ring_buffer.sv
// Sample history register array: one write/clear port, one combinational read port.
module sample_ring_buffer
  import synth_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             clr_en,
  input  logic [PTR_W-1:0] wr_idx,
  input  sample_t          wr_data,
  input  logic [PTR_W-1:0] rd_idx,
  output sample_t          rd_data
);

  sample_t mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en || clr_en) begin
      mem[wr_idx] <= clr_en ? '0 : wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/moving_average_hpf.sv
// Boxcar moving-average high-pass: output = x minus the mean of the last 2^order samples.
module moving_average_hpf
  import synth_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  moving_average_hpf_if.slave bus
);

  hpf_state_t             state;
  logic [ORD_W-1:0]       order_reg;
  logic [ORD_W-1:0]       flush_order;
  logic [PTR_W-1:0]       flush_cnt;
  logic [PTR_W-1:0]       wr_ptr;
  logic signed [SUM_W-1:0] sum;
  logic [MAX_ORDER:0]     fill;

  logic [ORD_W-1:0]        order_clamped;
  logic [MAX_ORDER:0]      n_win;
  logic [MAX_ORDER:0]      fill_next;
  logic [PTR_W-1:0]        rd_idx;
  sample_t                 old_sample;
  logic signed [SUM_W-1:0] sum_next;
  logic signed [SUM_W-1:0] mean_full;
  logic signed [SAMPLE_W:0] diff;
  logic                    accept;

  assign order_clamped = (bus.order > 4'(MAX_ORDER)) ? ORD_W'(MAX_ORDER) : bus.order[ORD_W-1:0];
  assign n_win         = {{MAX_ORDER{1'b0}}, 1'b1} << order_reg;
  // N = DEPTH truncates to 0 here, so the oldest entry is the one about to be overwritten.
  assign rd_idx        = wr_ptr - n_win[PTR_W-1:0];
  assign fill_next     = (fill == n_win) ? fill : fill + 1'b1;

  // An order change in RUN wins over a same-cycle sample.
  assign accept = (state == RUN) && (order_clamped == order_reg) && bus.in_valid;

  always_comb begin
    sum_next  = sum
              + {{(SUM_W-SAMPLE_W){bus.signal_in[SAMPLE_W-1]}}, bus.signal_in}
              - {{(SUM_W-SAMPLE_W){old_sample[SAMPLE_W-1]}}, old_sample};
    mean_full = sum_next >>> order_reg;
    diff      = {bus.signal_in[SAMPLE_W-1], bus.signal_in} - mean_full[SAMPLE_W:0];
  end

  sample_ring_buffer u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .clr_en  (state == FLUSH),
    .wr_idx  ((state == FLUSH) ? flush_cnt : wr_ptr),
    .wr_data (bus.signal_in),
    .rd_idx  (rd_idx),
    .rd_data (old_sample)
  );

  assign bus.in_ready = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      order_reg      <= order_clamped;
      flush_order    <= order_clamped;
      flush_cnt      <= '0;
      wr_ptr         <= '0;
      sum            <= '0;
      fill           <= '0;
      bus.settled    <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.signal_out <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      unique case (state)
        RUN: begin
          if (order_clamped != order_reg) begin
            state       <= FLUSH;
            flush_order <= order_clamped;
            flush_cnt   <= '0;
          end else if (bus.in_valid) begin
            wr_ptr         <= wr_ptr + 1'b1;
            sum            <= sum_next;
            fill           <= fill_next;
            bus.settled    <= (fill_next == n_win);
            bus.out_valid  <= 1'b1;
            bus.signal_out <= sat_sample(diff);
          end
        end
        FLUSH: begin
          if (order_clamped != flush_order) begin
            flush_order <= order_clamped;
            flush_cnt   <= '0;
          end else if (flush_cnt == PTR_W'(DEPTH - 1)) begin
            state       <= RUN;
            order_reg   <= flush_order;
            sum         <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            bus.settled <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_moving_average_hpf.sv
// Scoreboard bench for moving_average_hpf against a window-mean reference model.
module tb_moving_average_hpf;

  logic clk = 1'b0;
  logic reset;

  moving_average_hpf_if bus ();

  moving_average_hpf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit settled;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   mdl_order;
  int   acc_cnt;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int floor_div(input int s, input int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  function automatic int clamp_order(input int o);
    return (o > 6) ? 6 : o;
  endfunction

  task automatic model_reset(input int o);
    hist.delete();
    acc_cnt   = 0;
    mdl_order = clamp_order(o);
  endtask

  // Expected result: x minus floor(mean of the last N accepted samples, absent ones as 0).
  task automatic model_push(input int x);
    int n, s, idx, d;
    exp_t e;
    hist.push_back(x);
    if (hist.size() > 64) void'(hist.pop_front());
    acc_cnt++;
    n = 1 << mdl_order;
    s = 0;
    for (int i = 0; i < n; i++) begin
      idx = hist.size() - 1 - i;
      if (idx >= 0) s += hist[idx];
    end
    d = x - floor_div(s, n);
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    e.val     = d;
    e.settled = (acc_cnt >= n);
    exp_q.push_back(e);
  endtask

  task automatic send(input int x);
    bus.in_valid  = 1'b1;
    bus.signal_in = 16'(x);
    model_push(x);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply an order; when the clamped value differs, expect a 64-cycle in_ready-low flush.
  task automatic set_order(input int o);
    int cnt;
    bit done;
    bus.order = 4'(o);
    if (clamp_order(o) != mdl_order) begin
      cnt  = 0;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
        @(negedge clk);
        if (!bus.in_ready) cnt++;
        else if (cnt > 0) done = 1'b1;
      end
      check("flush_len", cnt, 64);
      model_reset(o);
    end else begin
      repeat (2) @(negedge clk);
      check("no_flush_ready", int'(bus.in_ready), 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(bus.in_ready), 1);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_signal_out"}, int'(bus.signal_out), 0);
    check({tag, "_settled"}, int'(bus.settled), 0);
  endtask

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got signal_out %0d, expected no output",
                 bus.signal_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("signal_out", int'(bus.signal_out), e.val);
        check("settled", int'(bus.settled), int'(e.settled));
      end
    end
  end

  initial begin
    int sq[3];
    sq[0] = 123;
    sq[1] = -4000;
    sq[2] = 32767;
    reset         = 1'b1;
    bus.order     = 4'd2;
    bus.in_valid  = 1'b0;
    bus.signal_in = '0;
    model_reset(2);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // DC step, order 2: 750, 500, 250, 0 then zeros.
    for (int i = 0; i < 8; i++) send(1000);
    idle(2);

    // Order 0: output always 0.
    set_order(0);
    for (int i = 0; i < 12; i++) begin
      send(sq[$urandom_range(2, 0)]);
      if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 1));
    end
    idle(2);

    // Saturation at full window.
    set_order(6);
    for (int i = 0; i < 63; i++) send(32767);
    send(-32768);
    idle(2);

    // Order change mid-stream 2 -> 3.
    set_order(2);
    for (int i = 0; i < 5; i++) send(int'($urandom_range(2000, 0)) - 1000);
    set_order(3);
    send(800);
    idle(2);

    // Square wave across pointer wrap.
    set_order(6);
    for (int i = 0; i < 200; i++) send((i % 2 == 0) ? 1000 : -1000);
    idle(2);

    // Clamp: 15 maps to 6, so no flush.
    set_order(15);
    for (int i = 0; i < 10; i++) send(int'($urandom_range(65535, 0)) - 32768);
    idle(2);

    // Random orders and samples with occasional gaps.
    for (int k = 0; k < 4; k++) begin
      set_order($urandom_range(5, 1));
      for (int i = 0; i < 40; i++) begin
        send(int'($urandom_range(65535, 0)) - 32768);
        if ($urandom_range(3, 0) == 0) idle(1);
      end
      idle(2);
    end

    // Reset mid-flush.
    bus.order = 4'd5;
    repeat (20) @(negedge clk);
    bus.order = 4'd2;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_flush");
    exp_q.delete();
    model_reset(2);
    @(negedge clk);
    reset = 1'b0;
    send(1000);
    for (int i = 0; i < 6; i++) send(int'($urandom_range(4000, 0)) - 2000);

    // Reset mid-stream.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_stream");
    exp_q.delete();
    model_reset(2);
    @(negedge clk);
    reset = 1'b0;
    send(1000);
    idle(3);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
